// File: rtl/digit_blink_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : digit_blink_ctrl
// Purpose  : Edit-session cursor and blink controller for a seven-segment
//            display. Optional macro CURSOR_WRAP_EN makes the cursor wrap
//            at the range ends instead of saturating.
// Revision : 1.0 - initial release
// ============================================================================
module digit_blink_ctrl #(
    parameter int DIGITS         = 6,
    parameter int BLINK_DIV      = 25_000_000,
    parameter int TIMEOUT_BLINKS = 10,
    parameter int SKIP_DIGIT     = DIGITS - 2
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      BTN_EDIT,
    input  logic                      BTN_LEFT,
    input  logic                      BTN_RIGHT,
    output logic                      BLINK,
    output logic                      COM,
    output logic [DIGITS-1:0]         SEL,
    output logic [$clog2(DIGITS)-1:0] CURSOR,
    output logic                      EDITING
);

    localparam int c_CUR_W = $clog2(DIGITS);
    localparam int c_BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int c_TO_W  = $clog2(2 * TIMEOUT_BLINKS);

    localparam logic [c_BLK_W-1:0] c_BLINK_LAST = c_BLK_W'(BLINK_DIV - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST    = c_TO_W'(2 * TIMEOUT_BLINKS - 1);

    // Lowest and highest indices the cursor may occupy.
    localparam int c_LO = (SKIP_DIGIT == 0) ? 1 : 0;
    localparam int c_HI = (SKIP_DIGIT == DIGITS - 1) ? DIGITS - 2 : DIGITS - 1;

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_EDIT = 1'b1;

    logic [0:0]         r_state;
    logic               r_prev_edit;
    logic               r_prev_left;
    logic               r_prev_right;
    logic               r_blink;
    logic [c_CUR_W-1:0] r_cursor;
    logic [c_BLK_W-1:0] r_blink_cnt;
    logic [c_TO_W-1:0]  r_to_cnt;

    logic [0:0]         w_state_nxt;
    logic               w_blink_nxt;
    logic [c_CUR_W-1:0] w_cursor_nxt;
    logic [c_BLK_W-1:0] w_blink_cnt_nxt;
    logic [c_TO_W-1:0]  w_to_cnt_nxt;

    logic               w_edit_edge;
    logic               w_left_edge;
    logic               w_right_edge;
    logic               w_tick;
    logic [c_CUR_W-1:0] w_left_tgt;
    logic [c_CUR_W-1:0] w_right_tgt;
    logic               w_left_ok;
    logic               w_right_ok;

    assign w_edit_edge  = BTN_EDIT  & ~r_prev_edit;
    assign w_left_edge  = BTN_LEFT  & ~r_prev_left;
    assign w_right_edge = BTN_RIGHT & ~r_prev_right;
    assign w_tick       = (r_blink_cnt == c_BLINK_LAST);

    // Candidate cursor targets; the ok flags are low only for refused moves.
    always_comb begin
        w_left_ok   = 1'b1;
        w_right_ok  = 1'b1;
        w_left_tgt  = r_cursor;
        w_right_tgt = r_cursor;
        if (int'(r_cursor) >= c_HI) begin
`ifdef CURSOR_WRAP_EN
            w_left_tgt = c_CUR_W'(c_LO);
`else
            w_left_ok  = 1'b0;
`endif
        end else if (int'(r_cursor) + 1 == SKIP_DIGIT) begin
            w_left_tgt = c_CUR_W'(int'(r_cursor) + 2);
        end else begin
            w_left_tgt = r_cursor + 1'b1;
        end
        if (int'(r_cursor) <= c_LO) begin
`ifdef CURSOR_WRAP_EN
            w_right_tgt = c_CUR_W'(c_HI);
`else
            w_right_ok  = 1'b0;
`endif
        end else if (int'(r_cursor) - 1 == SKIP_DIGIT) begin
            w_right_tgt = c_CUR_W'(int'(r_cursor) - 2);
        end else begin
            w_right_tgt = r_cursor - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state      <= c_IDLE;
            r_prev_edit  <= 1'b1;
            r_prev_left  <= 1'b1;
            r_prev_right <= 1'b1;
            r_blink      <= 1'b1;
            r_cursor     <= '0;
            r_blink_cnt  <= '0;
            r_to_cnt     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev_edit  <= BTN_EDIT;
            r_prev_left  <= BTN_LEFT;
            r_prev_right <= BTN_RIGHT;
            r_blink      <= w_blink_nxt;
            r_cursor     <= w_cursor_nxt;
            r_blink_cnt  <= w_blink_cnt_nxt;
            r_to_cnt     <= w_to_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_blink_nxt     = r_blink;
        w_cursor_nxt    = r_cursor;
        w_blink_cnt_nxt = r_blink_cnt;
        w_to_cnt_nxt    = r_to_cnt;
        case (r_state)
            c_IDLE: begin
                w_blink_nxt     = 1'b1;
                w_blink_cnt_nxt = '0;
                w_to_cnt_nxt    = '0;
                if (w_edit_edge) begin
                    w_state_nxt  = c_EDIT;
                    w_cursor_nxt = c_CUR_W'(c_LO);
                end
            end
            default: begin
                w_blink_cnt_nxt = w_tick ? '0 : r_blink_cnt + 1'b1;
                if (w_tick) begin
                    w_blink_nxt  = ~r_blink;
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
                end
                if (w_edit_edge) begin
                    w_state_nxt     = c_IDLE;
                    w_blink_nxt     = 1'b1;
                    w_blink_cnt_nxt = '0;
                    w_to_cnt_nxt    = '0;
                end else if (w_left_edge | w_right_edge) begin
                    // Refused or conflicting moves only restart the timeout.
                    w_to_cnt_nxt = '0;
                    if (w_left_edge && !w_right_edge && w_left_ok) begin
                        w_cursor_nxt    = w_left_tgt;
                        w_blink_nxt     = 1'b1;
                        w_blink_cnt_nxt = '0;
                    end else if (w_right_edge && !w_left_edge && w_right_ok) begin
                        w_cursor_nxt    = w_right_tgt;
                        w_blink_nxt     = 1'b1;
                        w_blink_cnt_nxt = '0;
                    end
                end else if (w_tick && r_to_cnt == c_TO_LAST) begin
                    w_state_nxt     = c_IDLE;
                    w_blink_nxt     = 1'b1;
                    w_blink_cnt_nxt = '0;
                    w_to_cnt_nxt    = '0;
                end
            end
        endcase
    end

    always_comb begin
        BLINK   = r_blink;
        CURSOR  = r_cursor;
        COM     = (r_state == c_IDLE);
        EDITING = (r_state == c_EDIT);
        SEL     = '0;
        if (r_state == c_EDIT) begin
            SEL = DIGITS'(1) << r_cursor;
        end
    end

endmodule
`default_nettype wire
